// File: rtl/despacho_pkg.sv
// despacho_pkg: opcodes, tag/sentinel constants and op-class decode for the Tomasulo issue stage
package despacho_pkg;

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_LD = 3'd4;
    localparam logic [2:0] OP_ST = 3'd5;
    localparam int TAG_FREE = 0;
    localparam logic [15:0] V_SENT = 16'hFFF0;
    localparam logic [6:0] A_SENT = 7'h70;

    typedef enum logic [1:0] {CLS_NOP, CLS_ALU, CLS_MEM} op_class_t;

    function automatic op_class_t op_class(input logic [2:0] op);
        return (op == OP_ADD || op == OP_SUB) ? CLS_ALU :
               (op == OP_LD || op == OP_ST) ? CLS_MEM : CLS_NOP;
    endfunction

endpackage

// File: rtl/alocador_estacao.sv
// alocador_estacao: find-first-zero over an effective-busy slice, lowest index wins
module alocador_estacao #(
    parameter int N = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  busy,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/unidade_despacho_n.sv
// unidade_despacho_n: Tomasulo issue stage with rename forwarding and stall counter;
// define DESPACHO_CDB_BYPASS_EN to take same-cycle CDB broadcasts into resolved sources
module unidade_despacho_n
    import despacho_pkg::*;
#(
    parameter int N_ADD = 2,
    parameter int N_LD = 2,
    parameter int NREG = 8,
    parameter int XLEN = 16,
    parameter int TAG_W = $clog2(N_ADD + N_LD + 1)
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    Inst_valid,
    input  logic [15:0]             Inst,
    output logic                    Inst_ready,
    input  logic [NREG*TAG_W-1:0]   Rs_Qi,
    input  logic [NREG*XLEN-1:0]    Rs_Qi_data,
    input  logic [N_ADD+N_LD-1:0]   Busy,
    input  logic                    Cdb_valid,
    input  logic [TAG_W-1:0]        Cdb_tag,
    input  logic [XLEN-1:0]         Cdb_data,
    output logic [N_ADD+N_LD-1:0]   Issue_en,
    output logic [2:0]              Issue_op,
    output logic [XLEN-1:0]         Vj,
    output logic [XLEN-1:0]         Vk,
    output logic [TAG_W-1:0]        Qj,
    output logic [TAG_W-1:0]        Qk,
    output logic [6:0]              A,
    output logic                    R_enable_despacho,
    output logic [2:0]              R_target_despacho,
    output logic [TAG_W-1:0]        R_res_station_despacho,
    output logic [15:0]             Stall_count
);

    localparam int NS = N_ADD + N_LD;
    localparam int AW = N_ADD > 1 ? $clog2(N_ADD) : 1;
    localparam int LW = N_LD > 1 ? $clog2(N_LD) : 1;

    logic [NS-1:0] eff, mask;
    logic add_found, ld_found, is_ld, is_st, ready_c, accept;
    logic [AW-1:0] add_idx;
    logic [LW-1:0] ld_idx;
    logic [2:0] op, ri, rj, rk;
    logic [TAG_W-1:0] tag;
    logic [1:0][2:0] src;
    logic [1:0][TAG_W-1:0] sq;
    logic [1:0][XLEN-1:0] sv;
    op_class_t cls;

    // Busy lags Issue_en by a cycle, so the station just issued must still read as taken
    assign eff = Busy | Issue_en;
    assign {op, ri, rj, rk} = Inst[15:4];
    assign cls = op_class(op);
    assign Inst_ready = Reset_n && ready_c;

    alocador_estacao #(.N(N_ADD), .IW(AW)) u_add (
        .busy(eff[N_ADD-1:0]), .found(add_found), .idx(add_idx));
    alocador_estacao #(.N(N_LD), .IW(LW)) u_ld (
        .busy(eff[NS-1:N_ADD]), .found(ld_found), .idx(ld_idx));

    always_comb begin
        is_ld = op == OP_LD;
        is_st = op == OP_ST;
        ready_c = cls == CLS_NOP || (cls == CLS_ALU ? add_found : ld_found);
        accept = Inst_valid && ready_c && cls != CLS_NOP;
        tag = cls == CLS_ALU ? TAG_W'(add_idx) + TAG_W'(1) : TAG_W'(N_ADD) + TAG_W'(ld_idx) + TAG_W'(1);
        mask = NS'(1) << (tag - TAG_W'(1));
        src[0] = rj;
        src[1] = is_st ? ri : rk;
        // Rs_Qi has not yet seen last cycle's rename, so that rename takes priority
        for (int i = 0; i < 2; i++) begin
            sq[i] = (R_enable_despacho && R_target_despacho == src[i]) ? R_res_station_despacho
                                                                       : Rs_Qi[int'(src[i])*TAG_W +: TAG_W];
            sv[i] = sq[i] == TAG_W'(TAG_FREE) ? Rs_Qi_data[int'(src[i])*XLEN +: XLEN] : XLEN'(V_SENT);
`ifdef DESPACHO_CDB_BYPASS_EN
            if (Cdb_valid && sq[i] != TAG_W'(TAG_FREE) && Cdb_tag == sq[i]) begin
                sv[i] = Cdb_data;
                sq[i] = TAG_W'(TAG_FREE);
            end
`endif
        end
    end

`ifndef DESPACHO_CDB_BYPASS_EN
    logic unused_cdb;
    assign unused_cdb = ^{Cdb_valid, Cdb_tag, Cdb_data};
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Issue_en <= '0;
            Issue_op <= '0;
            Vj <= XLEN'(V_SENT);
            Vk <= XLEN'(V_SENT);
            Qj <= '0;
            Qk <= '0;
            A <= A_SENT;
            R_enable_despacho <= 1'b0;
            R_target_despacho <= '0;
            R_res_station_despacho <= '0;
            Stall_count <= '0;
        end else begin
            Issue_en <= accept ? mask : '0;
            R_enable_despacho <= accept && !is_st;
            if (accept) begin
                Issue_op <= op;
                Vj <= sv[0];
                Qj <= sq[0];
                Vk <= is_ld ? XLEN'(V_SENT) : sv[1];
                Qk <= is_ld ? '0 : sq[1];
                A <= cls == CLS_MEM ? Inst[6:0] : A_SENT;
            end
            if (accept && !is_st) begin
                R_target_despacho <= ri;
                R_res_station_despacho <= tag;
            end
            if (Inst_valid && !ready_c && Stall_count != 16'hFFFF)
                Stall_count <= Stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_unidade_despacho_n.sv
// tb_unidade_despacho_n: directed stimulus with a queue scoreboard checked by an output monitor
module tb_unidade_despacho_n;

    typedef struct {
        int due;
        logic [3:0] en;
        logic [2:0] op;
        logic [15:0] vj, vk;
        logic [2:0] qj, qk;
        logic [6:0] a;
        logic ma;
        logic ren;
        logic [2:0] rt, rq;
    } exp_t;

    logic clk = 0, rst_n = 0;
    logic inst_valid;
    logic [15:0] inst;
    logic inst_ready;
    logic [23:0] rs_qi;
    logic [127:0] rs_qi_data;
    logic [3:0] busy;
    logic cdb_valid;
    logic [2:0] cdb_tag;
    logic [15:0] cdb_data;
    logic [3:0] issue_en;
    logic [2:0] issue_op;
    logic [15:0] vj, vk;
    logic [2:0] qj, qk;
    logic [6:0] a;
    logic r_en;
    logic [2:0] r_tgt, r_tag;
    logic [15:0] stall_count;

    int total = 0, bad = 0, cyc = 0;
    exp_t q[$];
    exp_t me, nil;

    unidade_despacho_n dut (
        .Clock(clk), .Reset_n(rst_n), .Inst_valid(inst_valid), .Inst(inst), .Inst_ready(inst_ready),
        .Rs_Qi(rs_qi), .Rs_Qi_data(rs_qi_data), .Busy(busy),
        .Cdb_valid(cdb_valid), .Cdb_tag(cdb_tag), .Cdb_data(cdb_data),
        .Issue_en(issue_en), .Issue_op(issue_op), .Vj(vj), .Vk(vk), .Qj(qj), .Qk(qk), .A(a),
        .R_enable_despacho(r_en), .R_target_despacho(r_tgt), .R_res_station_despacho(r_tag),
        .Stall_count(stall_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rd(input int r);
        return 16'hA000 + 16'(r) * 16'h0111;
    endfunction

    function automatic logic [15:0] alu(input logic [2:0] op, ri, rj, rk);
        return {op, ri, rj, rk, 4'b0};
    endfunction

    function automatic logic [15:0] mem(input logic [2:0] op, ri, rj, input logic [6:0] imm);
        return {op, ri, rj, imm};
    endfunction

    function automatic exp_t mk(input logic [3:0] en, input logic [2:0] op, input logic [15:0] vj_e,
                                input logic [2:0] qj_e, input logic [15:0] vk_e, input logic [2:0] qk_e,
                                input logic [6:0] a_e, input logic ma, input logic ren,
                                input logic [2:0] rt, input logic [2:0] rq);
        exp_t e;
        e.due = 0; e.en = en; e.op = op; e.vj = vj_e; e.qj = qj_e; e.vk = vk_e; e.qk = qk_e;
        e.a = a_e; e.ma = ma; e.ren = ren; e.rt = rt; e.rq = rq;
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic exp_rdy,
                         input logic push, input exp_t e);
        exp_t x;
        @(negedge clk);
        inst_valid = v;
        inst = ins;
        #1;
        chk("inst_ready", {31'b0, inst_ready}, {31'b0, exp_rdy});
        if (push) begin
            x = e;
            x.due = cyc + 1;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        inst_valid = 0;
    endtask

    task automatic idle();
        @(negedge clk);
        inst_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_issue_en", {28'b0, issue_en}, 0);
        chk("rst_r_en", {31'b0, r_en}, 0);
        chk("rst_op", {29'b0, issue_op}, 0);
        chk("rst_vj", {16'b0, vj}, 32'hFFF0);
        chk("rst_vk", {16'b0, vk}, 32'hFFF0);
        chk("rst_qj", {29'b0, qj}, 0);
        chk("rst_qk", {29'b0, qk}, 0);
        chk("rst_a", {25'b0, a}, 32'h70);
        chk("rst_r_tgt", {29'b0, r_tgt}, 0);
        chk("rst_r_tag", {29'b0, r_tag}, 0);
        chk("rst_stall", {16'b0, stall_count}, 0);
        chk("rst_ready", {31'b0, inst_ready}, 0);
    endtask

    always @(negedge clk) begin
        if (issue_en != 0 || r_en) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_issue got en=%b ren=%b want none", issue_en, r_en);
            end else begin
                me = q.pop_front();
                chk("issue_cycle", cyc, me.due);
                chk("issue_en", {28'b0, issue_en}, {28'b0, me.en});
                chk("issue_op", {29'b0, issue_op}, {29'b0, me.op});
                chk("vj", {16'b0, vj}, {16'b0, me.vj});
                chk("qj", {29'b0, qj}, {29'b0, me.qj});
                chk("vk", {16'b0, vk}, {16'b0, me.vk});
                chk("qk", {29'b0, qk}, {29'b0, me.qk});
                chk("r_enable", {31'b0, r_en}, {31'b0, me.ren});
                if (me.ma) chk("a", {25'b0, a}, {25'b0, me.a});
                if (me.ren) begin
                    chk("r_target", {29'b0, r_tgt}, {29'b0, me.rt});
                    chk("r_tag", {29'b0, r_tag}, {29'b0, me.rq});
                end
            end
        end
        if (q.size() > 0 && q[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_issue got none want en=%b at cycle %0d", q[0].en, q[0].due);
            void'(q.pop_front());
        end
    end

    initial begin
        inst_valid = 1;
        inst = alu(3'd2, 3'd1, 3'd2, 3'd3);
        rs_qi = '0;
        busy = '0;
        cdb_valid = 0;
        cdb_tag = '0;
        cdb_data = '0;
        for (int r = 0; r < 8; r++) rs_qi_data[r*16 +: 16] = rd(r);
        #12;
        chk_reset();
        @(negedge clk);
        rst_n = 1;
        inst_valid = 0;
        // ADD R1,R2,R3 from all-free state
        drive(1, alu(3'd2, 3'd1, 3'd2, 3'd3), 1, 1,
              mk(4'b0001, 3'd2, rd(2), 0, rd(3), 0, 0, 0, 1, 3'd1, 3'd1));
        // ADD R4,R1,R2 back to back: next station, R1 forwarded from last rename
        drive(1, alu(3'd2, 3'd4, 3'd1, 3'd2), 1, 1,
              mk(4'b0010, 3'd2, 16'hFFF0, 3'd1, rd(2), 0, 0, 0, 1, 3'd4, 3'd2));
        busy = 4'b0011;
        for (int i = 0; i < 3; i++) drive(1, alu(3'd2, 3'd5, 3'd6, 3'd7), 0, 0, nil);
        chk("stall_count_3", {16'b0, stall_count}, 3);
        drive(1, alu(3'd0, 3'd5, 3'd6, 3'd7), 1, 0, nil);
        chk("stall_after_nop", {16'b0, stall_count}, 3);
        rs_qi[5*3 +: 3] = 3'd3;
        // ST R5 -> Qk from Rs_Qi[5], no rename
        drive(1, mem(3'd5, 3'd5, 3'd6, 7'h2A), 1, 1,
              mk(4'b0100, 3'd5, rd(6), 0, 16'hFFF0, 3'd3, 7'h2A, 1, 0, 0, 0));
        // LD right after: ST's station still effectively busy
        drive(1, mem(3'd4, 3'd7, 3'd5, 7'h15), 1, 1,
              mk(4'b1000, 3'd4, 16'hFFF0, 3'd3, 16'hFFF0, 0, 7'h15, 1, 1, 3'd7, 3'd4));
        busy = 4'b0111;
        drive(1, mem(3'd4, 3'd3, 3'd7, 7'h01), 0, 0, nil);
        chk("stall_count_4", {16'b0, stall_count}, 4);
        busy = 4'b0000;
        idle();
        rs_qi = '0;
        rs_qi[2*3 +: 3] = 3'd4;
        cdb_valid = 1;
        cdb_tag = 3'd4;
        cdb_data = 16'h0123;
        // ADD R2,R2,R3: self dependence resolves to old producer 4
`ifdef DESPACHO_CDB_BYPASS_EN
        drive(1, alu(3'd2, 3'd2, 3'd2, 3'd3), 1, 1,
              mk(4'b0001, 3'd2, 16'h0123, 0, rd(3), 0, 0, 0, 1, 3'd2, 3'd1));
`else
        drive(1, alu(3'd2, 3'd2, 3'd2, 3'd3), 1, 1,
              mk(4'b0001, 3'd2, 16'hFFF0, 3'd4, rd(3), 0, 0, 0, 1, 3'd2, 3'd1));
`endif
        cdb_valid = 0;
        // SUB R6,R2,R2: both sources forwarded from the rename just made
        drive(1, alu(3'd3, 3'd6, 3'd2, 3'd2), 1, 1,
              mk(4'b0010, 3'd3, 16'hFFF0, 3'd1, 16'hFFF0, 3'd1, 0, 0, 1, 3'd6, 3'd2));
        idle();
        rs_qi = '0;
        drive(1, alu(3'd2, 3'd1, 3'd3, 3'd3), 1, 0, nil);
        inst_valid = 1;
        rst_n = 0;
        @(negedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1;
        inst_valid = 0;
        // forward state cleared: R1 comes from the register file
        drive(1, alu(3'd2, 3'd5, 3'd1, 3'd1), 1, 1,
              mk(4'b0001, 3'd2, rd(1), 0, rd(1), 0, 0, 0, 1, 3'd5, 3'd1));
        for (int i = 0; i < 3; i++) idle();
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
